branch_predict_unit: RTL and testbench

Parametrised branch resolution and prediction block for the rv32ui core. It evaluates the six RV32I conditional-branch comparisons and selects the next PC, like the existing combinational resolver. It also holds a branch history table (BHT) of 2-bit saturating counters that supplies a taken/not-taken prediction at fetch. The unit is trained on every resolved branch and flags mispredictions to the fetch/redirect logic.

---
 rtl/branch_predict_unit_if.sv | 35 +++
 rtl/branch_predict_unit.sv | 86 ++++++++
 tb/tb_branch_predict_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// Fetch-prediction and branch-resolution bundle for branch_predict_unit.
// The master drives fetch/resolve inputs, and the slave returns the results.
interface branch_predict_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] fetch_pc;
    logic            pred_taken;
    logic            resolve_valid;
    logic [XLEN-1:0] resolve_pc;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc4;
    logic            resolve_pred;
    logic [XLEN-1:0] branch_out;
    logic            taken;
    logic            mispredict;
    logic [31:0]     branch_count;
    logic [31:0]     mispredict_count;

    modport master (
        output fetch_pc, resolve_valid, resolve_pc, funct3,
        output rs1_data, rs2_data, target, pc4, resolve_pred,
        input  pred_taken, branch_out, taken, mispredict,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  fetch_pc, resolve_valid, resolve_pc, funct3,
        input  rs1_data, rs2_data, target, pc4, resolve_pred,
        output pred_taken, branch_out, taken, mispredict,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predict_unit.sv
// RV32I branch resolver with a 2-bit saturating-counter BHT.
// Optional statistics counters: define BRANCH_PREDICT_STATS_EN.
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input logic                 clk,
    input logic                 reset,
    branch_predict_unit_if.slave bp
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] fidx;
    logic [IDX_W-1:0] ridx;
    logic             cond;
    logic             legal;
    logic             upd;
    logic             unused;

    assign fidx = bp.fetch_pc[IDX_W+1:2];
    assign ridx = bp.resolve_pc[IDX_W+1:2];

    // funct3 010/011 are the only holes in the branch encoding
    assign legal = ~(~bp.funct3[2] & bp.funct3[1]);
    assign upd   = bp.resolve_valid & legal;

    always_comb begin
        cond = 1'b0;
        unique case (bp.funct3)
            3'b000:  cond = (bp.rs1_data == bp.rs2_data);
            3'b001:  cond = (bp.rs1_data != bp.rs2_data);
            3'b100:  cond = ($signed(bp.rs1_data) < $signed(bp.rs2_data));
            3'b101:  cond = ($signed(bp.rs1_data) >= $signed(bp.rs2_data));
            3'b110:  cond = (bp.rs1_data < bp.rs2_data);
            3'b111:  cond = (bp.rs1_data >= bp.rs2_data);
            default: cond = 1'b0;
        endcase
    end

    assign bp.taken      = bp.resolve_valid & cond;
    assign bp.branch_out = bp.taken ? bp.target : bp.pc4;
    assign bp.mispredict = bp.resolve_valid & (bp.taken ^ bp.resolve_pred);
    assign bp.pred_taken = ~reset & bht[fidx][1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (upd) begin
            if (bp.taken && bht[ridx] != 2'b11) begin
                bht[ridx] <= bht[ridx] + 2'b01;
            end else if (!bp.taken && bht[ridx] != 2'b00) begin
                bht[ridx] <= bht[ridx] - 2'b01;
            end
        end
    end

`ifdef BRANCH_PREDICT_STATS_EN
    logic [31:0] bcnt;
    logic [31:0] mcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt <= '0;
            mcnt <= '0;
        end else if (upd) begin
            bcnt <= bcnt + 32'd1;
            if (bp.mispredict) begin
                mcnt <= mcnt + 32'd1;
            end
        end
    end

    assign bp.branch_count     = bcnt;
    assign bp.mispredict_count = mcnt;
`else
    assign bp.branch_count     = '0;
    assign bp.mispredict_count = '0;
`endif

    // PC bits outside the index field do not select a counter
    assign unused = ^{bp.fetch_pc[1:0], bp.fetch_pc[XLEN-1:IDX_W+2],
                      bp.resolve_pc[1:0], bp.resolve_pc[XLEN-1:IDX_W+2]};
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed and randomized bench for branch_predict_unit.
// Reference model: integer counter array plus plain compare rules.
module tb_branch_predict_unit;
    localparam int XLEN = 32;
    localparam int N    = 64;
`ifdef BRANCH_PREDICT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    branch_predict_unit_if #(.XLEN(XLEN)) bp ();

    branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp.slave)
    );

    always #5 clk = ~clk;

    int          bht [N];
    int unsigned m_bc;
    int unsigned m_mc;
    int          errors = 0;
    int          checks = 0;

    function automatic int idx(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic bit is_legal(input logic [2:0] f);
        return !(f == 3'd2 || f == 3'd3);
    endfunction

    function automatic bit rule(input logic [2:0] f,
                                input logic [31:0] a, b);
        int          sa;
        int          sb;
        longint      ua;
        longint      ub;
        sa = a;
        sb = b;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f)
            3'd0:    return ua == ub;
            3'd1:    return ua != ub;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return ua < ub;
            3'd7:    return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_taken();
        return bp.resolve_valid && rule(bp.funct3, bp.rs1_data, bp.rs2_data);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit t;
        t = m_taken();
        chk({tag, ".taken"}, 32'(bp.taken), 32'(t));
        chk({tag, ".bout"}, bp.branch_out, t ? bp.target : bp.pc4);
        chk({tag, ".misp"}, 32'(bp.mispredict),
            32'(bp.resolve_valid && (t != bp.resolve_pred)));
        chk({tag, ".pred"}, 32'(bp.pred_taken),
            32'(!reset && bht[idx(bp.fetch_pc)] >= 2));
        chk({tag, ".bc"}, bp.branch_count, STATS ? m_bc : 32'd0);
        chk({tag, ".mc"}, bp.mispredict_count, STATS ? m_mc : 32'd0);
    endtask

    task automatic drive(input bit v, input logic [31:0] pc,
                         input logic [2:0] f, input logic [31:0] a, b,
                         input bit pred, input logic [31:0] fpc);
        bp.resolve_valid = v;
        bp.resolve_pc    = pc;
        bp.funct3        = f;
        bp.rs1_data      = a;
        bp.rs2_data      = b;
        bp.resolve_pred  = pred;
        bp.fetch_pc      = fpc;
        bp.target        = $urandom;
        bp.pc4           = pc + 32'd4;
        #1;
    endtask

    task automatic tick();
        bit t;
        int i;
        if (reset) begin
            foreach (bht[k]) bht[k] = 1;
            m_bc = 0;
            m_mc = 0;
        end else if (bp.resolve_valid && is_legal(bp.funct3)) begin
            t = m_taken();
            i = idx(bp.resolve_pc);
            bht[i] = t ? ((bht[i] < 3) ? bht[i] + 1 : 3)
                       : ((bht[i] > 0) ? bht[i] - 1 : 0);
            m_bc++;
            if (t != bp.resolve_pred) m_mc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] fpc);
        drive(1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, fpc);
    endtask

    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;

    initial begin
        foreach (bht[k]) bht[k] = 1;
        m_bc = 0;
        m_mc = 0;
        idle(32'h40);
        tick();
        tick();
        reset = 1'b0;
        idle(32'h40);
        check_all("rst");
        chk("rst_pred40", 32'(bp.pred_taken), 32'd0);

        // comparison results, no clock edge so the BHT is untouched
        drive(1'b1, 32'h200, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h40);
        bp.target = 32'h100;
        bp.pc4    = 32'h24;
        #1;
        chk("blt.taken", 32'(bp.taken), 32'd1);
        chk("blt.bout", bp.branch_out, 32'h100);
        bp.funct3 = 3'b110;
        #1;
        chk("bltu.taken", 32'(bp.taken), 32'd0);
        chk("bltu.bout", bp.branch_out, 32'h24);
        bp.funct3   = 3'b000;
        bp.rs2_data = 32'hFFFF_FFFF;
        #1;
        chk("beq.taken", 32'(bp.taken), 32'd1);
        bp.funct3 = 3'b001;
        #1;
        chk("bne.taken", 32'(bp.taken), 32'd0);
        idle(32'h40);

        // train 0x40 up, check aliasing, then saturate down
        repeat (2) begin
            drive(1'b1, 32'h40, 3'b000, 32'd7, 32'd7, 1'b0, 32'h40);
            check_all("train_t");
            tick();
        end
        idle(32'h40);
        chk("pred40_t", 32'(bp.pred_taken), 32'd1);
        idle(32'h140);
        chk("alias140", 32'(bp.pred_taken), 32'd1);
        idle(32'h44);
        chk("diff44", 32'(bp.pred_taken), 32'd0);
        repeat (4) begin
            drive(1'b1, 32'h40, 3'b001, 32'd7, 32'd7, 1'b1, 32'h40);
            check_all("train_nt");
            tick();
        end
        idle(32'h40);
        chk("pred40_nt", 32'(bp.pred_taken), 32'd0);
        repeat (2) begin
            drive(1'b1, 32'h40, 3'b000, 32'd3, 32'd3, 1'b0, 32'h40);
            check_all("retrain");
            tick();
        end
        idle(32'h40);
        chk("sat00_then_2t", 32'(bp.pred_taken), 32'd1);

        // same-cycle read of the written entry returns the old value
        drive(1'b1, 32'h80, 3'b000, 32'd1, 32'd1, 1'b0, 32'h80);
        chk("rw_old", 32'(bp.pred_taken), 32'd0);
        tick();
        idle(32'h80);
        chk("rw_new", 32'(bp.pred_taken), 32'd1);

        // illegal funct3
        drive(1'b1, 32'h80, 3'b010, 32'd1, 32'd1, 1'b1, 32'h80);
        chk("ill.bout", bp.branch_out, bp.pc4);
        chk("ill.misp", 32'(bp.mispredict), 32'd1);
        check_all("ill");
        tick();
        drive(1'b1, 32'h80, 3'b001, 32'd1, 32'd1, 1'b0, 32'h80);
        check_all("ill_after");
        tick();
        idle(32'h80);
        chk("ill_unchanged", 32'(bp.pred_taken), 32'd0);

        // statistics, then mid-run reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h100 + 32'(k * 4), 3'b000, 32'd5, 32'd5,
                  (k == 2 || k == 4) ? 1'b0 : 1'b1, 32'h0);
            tick();
        end
        idle(32'h0);
        chk("stat_bc5", bp.branch_count, STATS ? 32'd5 : 32'd0);
        chk("stat_mc2", bp.mispredict_count, STATS ? 32'd2 : 32'd0);
        drive(1'b1, 32'h100, 3'b000, 32'd5, 32'd5, 1'b0, 32'h100);
        reset = 1'b1;
        #1;
        chk("rst_pred0", 32'(bp.pred_taken), 32'd0);
        tick();
        reset = 1'b0;
        idle(32'h0);
        chk("rst_bc", bp.branch_count, 32'd0);
        chk("rst_mc", bp.mispredict_count, 32'd0);
        for (int k = 0; k < N; k++) begin
            idle(32'(k * 4));
            chk("rst_entry", 32'(bp.pred_taken), 32'd0);
        end
        drive(1'b1, 32'h104, 3'b000, 32'd5, 32'd5, 1'b0, 32'h104);
        tick();
        idle(32'h104);
        chk("rst_is_01", 32'(bp.pred_taken), 32'd1);

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 59) == 0);
            pc = (32'($urandom_range(0, 3)) << 8) |
                 (32'($urandom_range(0, 7)) << 2) |
                 32'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ 32'h8000_0000;
                default: b = $urandom;
            endcase
            drive($urandom_range(0, 3) != 0, pc, 3'($urandom_range(0, 7)),
                  a, b, 1'($urandom),
                  ($urandom_range(0, 1) == 0) ? pc : 32'($urandom) & 32'h3FC);
            check_all("rand");
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
